// File: rtl/mpu_sample_streamer.sv
// rtl/mpu_sample_streamer.sv - accelerometer X capture, x100 scaling and gesture stream handshake
module mpu_sample_streamer #(
    parameter int N_SAMPLES   = 30,
    parameter int DECIM       = 1,
    parameter int SCALE_MUL   = 981,
    parameter int SCALE_SHIFT = 14,
    parameter int TIMEOUT     = 65535,
    parameter int GAP         = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               raw_valid,
    input  logic signed [15:0] raw_accel,
    input  logic               srgl_ready,
    output logic               mov,
    output logic signed [31:0] mpu_valor,
    output logic               mpu_valid,
    output logic               busy,
    output logic               done,
    output logic               timeout
);

    localparam int SW = $clog2(N_SAMPLES + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP + 1);

    localparam logic [SW-1:0]      SAMPLE_LAST = SW'(N_SAMPLES - 1);
    localparam logic [3:0]         DECIM_LAST  = 4'(DECIM - 1);
    localparam logic [WW-1:0]      WAIT_LAST   = WW'(TIMEOUT - 1);
    localparam logic [GW-1:0]      GAP_LAST    = GW'(GAP - 1);
    localparam logic signed [31:0] MUL         = 32'(SCALE_MUL);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STREAM   = 2'd1,
        WAIT_RDY = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [SW-1:0] sample_cnt;
    logic [3:0]    decim_cnt;
    logic [WW-1:0] wait_cnt;
    logic [GW-1:0] gap_cnt;

    logic capture;   // start honoured in IDLE
    logic accept;    // raw sample taken while streaming
    logic forward;   // accepted sample survives decimation
    logic expire;    // classifier never answered, forced release

    logic signed [31:0] prod;
    logic signed [31:0] scaled;

    // 16x10-bit product always fits in 32 bits; arithmetic shift floors toward -inf
    assign prod   = $signed({{16{raw_accel[15]}}, raw_accel}) * MUL;
    assign scaled = prod >>> SCALE_SHIFT;

    assign busy = (state != IDLE);

    // State register; async reset abandons any stream in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-state strobes; mov keeps the classifier buffer alive
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        accept    = 1'b0;
        forward   = 1'b0;
        expire    = 1'b0;
        mov       = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    capture   = 1'b1;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                mov     = 1'b1;
                accept  = raw_valid;
                forward = raw_valid && (decim_cnt == 4'd0);
                if (forward && (sample_cnt == SAMPLE_LAST)) begin
                    state_nxt = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                mov = 1'b1;
                if (srgl_ready) begin
                    state_nxt = RELEASE;
                end else if (wait_cnt == WAIT_LAST) begin
                    expire    = 1'b1;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                done = (gap_cnt == '0);
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Sample datapath, counters and the sticky timeout flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mpu_valor  <= '0;
            mpu_valid  <= 1'b0;
            sample_cnt <= '0;
            decim_cnt  <= '0;
            wait_cnt   <= '0;
            gap_cnt    <= '0;
            timeout    <= 1'b0;
        end else begin
            mpu_valid <= forward;
            if (forward) begin
                mpu_valor  <= scaled;
                sample_cnt <= sample_cnt + SW'(1);
            end
            if (accept) begin
                decim_cnt <= (decim_cnt == DECIM_LAST) ? 4'd0 : decim_cnt + 4'd1;
            end
            if (capture) begin
                sample_cnt <= '0;
                decim_cnt  <= '0;
                timeout    <= 1'b0;
            end
            wait_cnt <= (state == WAIT_RDY) ? wait_cnt + WW'(1) : '0;
            gap_cnt  <= (state == RELEASE) ? gap_cnt + GW'(1) : '0;
            if (expire) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mpu_sample_streamer.sv
// tb/tb_mpu_sample_streamer.sv - scoreboard bench for mpu_sample_streamer (DECIM 1 and 2 instances)
module tb_mpu_sample_streamer;

    localparam int N       = 30;
    localparam int TO      = 100;
    localparam int DECIM_A = 1;
    localparam int DECIM_B = 2;

    logic clk = 1'b0;
    logic reset;

    logic               start_a, raw_valid_a, ready_a;
    logic signed [15:0] raw_a;
    logic               mov_a, valid_a, busy_a, done_a, timeout_a;
    logic signed [31:0] valor_a;

    logic               start_b, raw_valid_b, ready_b;
    logic signed [15:0] raw_b;
    logic               mov_b, valid_b, busy_b, done_b, timeout_b;
    logic signed [31:0] valor_b;

    typedef struct {
        int cyc;
        int val;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int cyc       = 0;
    int checks    = 0;
    int errors    = 0;
    int strobes_a = 0;
    int strobes_b = 0;

    int tab_raw[6] = '{16384, -8192, -32768, 0, 32767, -1};
    int tab_exp[6] = '{981, -491, -1962, 0, 1961, -1};

    mpu_sample_streamer #(
        .N_SAMPLES(N), .DECIM(DECIM_A), .SCALE_MUL(981), .SCALE_SHIFT(14), .TIMEOUT(TO), .GAP(2)
    ) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .raw_valid(raw_valid_a), .raw_accel(raw_a),
        .srgl_ready(ready_a), .mov(mov_a), .mpu_valor(valor_a), .mpu_valid(valid_a),
        .busy(busy_a), .done(done_a), .timeout(timeout_a)
    );

    mpu_sample_streamer #(
        .N_SAMPLES(N), .DECIM(DECIM_B), .SCALE_MUL(981), .SCALE_SHIFT(14), .TIMEOUT(TO), .GAP(2)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .raw_valid(raw_valid_b), .raw_accel(raw_b),
        .srgl_ready(ready_b), .mov(mov_b), .mpu_valor(valor_b), .mpu_valid(valid_b),
        .busy(busy_b), .done(done_b), .timeout(timeout_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference scaling: floor(raw * 9.81 * 100 / 16384) in plain integer arithmetic
    function automatic int scale_ref(input int raw);
        int p;
        p = raw * 981;
        if (p >= 0) return p / 16384;
        return -((-p + 16383) / 16384);
    endfunction

    function automatic logic get_mov(input int w);     return (w == 0) ? mov_a : mov_b;         endfunction
    function automatic logic get_busy(input int w);    return (w == 0) ? busy_a : busy_b;       endfunction
    function automatic logic get_done(input int w);    return (w == 0) ? done_a : done_b;       endfunction
    function automatic logic get_timeout(input int w); return (w == 0) ? timeout_a : timeout_b; endfunction
    function automatic int   qsize(input int w);       return (w == 0) ? qa.size() : qb.size(); endfunction

    task automatic chk(input string name, input logic signed [31:0] got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d required %0d", name, cyc, got, exp);
        end
    endtask

    task automatic drive(input int w, input logic st, input logic rv,
                         input logic signed [15:0] raw, input logic rdy);
        if (w == 0) begin
            start_a = st; raw_valid_a = rv; raw_a = raw; ready_a = rdy;
        end else begin
            start_b = st; raw_valid_b = rv; raw_b = raw; ready_b = rdy;
        end
    endtask

    task automatic push_exp(input int w, input int c, input int v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        if (w == 0) qa.push_back(e);
        else qb.push_back(e);
    endtask

    task automatic mon_check(input int w, input logic signed [31:0] val, input logic m);
        exp_t e;
        checks++;
        if (qsize(w) == 0) begin
            errors++;
            $display("FAIL strobe_dut%0d unexpected at cycle %0d: got valor %0d, required no strobe", w, cyc, val);
        end else begin
            if (w == 0) e = qa.pop_front();
            else e = qb.pop_front();
            if (val !== e.val || cyc != e.cyc) begin
                errors++;
                $display("FAIL strobe_dut%0d: got valor %0d at cycle %0d, required %0d at cycle %0d",
                         w, val, cyc, e.val, e.cyc);
            end
        end
        chk("mov_at_strobe", m, 1);
        if (w == 0) strobes_a++;
        else strobes_b++;
    endtask

    // Monitor: every strobe must match the head of that instance's expected queue
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (valid_a === 1'b1) mon_check(0, valor_a, mov_a);
            if (valid_b === 1'b1) mon_check(1, valor_b, mov_b);
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_mov_a"}, mov_a, 0);       chk({tag, "_mov_b"}, mov_b, 0);
        chk({tag, "_valor_a"}, valor_a, 0);   chk({tag, "_valor_b"}, valor_b, 0);
        chk({tag, "_valid_a"}, valid_a, 0);   chk({tag, "_valid_b"}, valid_b, 0);
        chk({tag, "_busy_a"}, busy_a, 0);     chk({tag, "_busy_b"}, busy_b, 0);
        chk({tag, "_done_a"}, done_a, 0);     chk({tag, "_done_b"}, done_b, 0);
        chk({tag, "_timeout_a"}, timeout_a, 0); chk({tag, "_timeout_b"}, timeout_b, 0);
    endtask

    // One gesture. pat: 0 random gappy, 1 all 16384, 2 random back-to-back, 3 directed table.
    // rel_mode: 0 ready after dly cycles, 1 timeout, 2 ready on the last timeout cycle.
    task automatic gesture(input int w, input int pat, input int rel_mode, input int dly);
        int d, k, fwd, guard, t, done_t, extra, exp_done, ev;
        logic rv, st, rdy, exp_to;
        logic signed [15:0] raw;
        d = (w == 0) ? DECIM_A : DECIM_B;
        k = 0; fwd = 0; guard = 0;
        drive(w, 1'b1, 1'b1, 16'sh1234, 1'b0);
        @(negedge clk);
        chk("busy_before_start", get_busy(w), 0);
        @(posedge clk); #1;
        while (fwd < N && guard < 4000) begin
            rv = (pat == 0) ? ($urandom_range(3) != 0) : 1'b1;
            case (pat)
                1:       raw = 16'sd16384;
                3:       raw = 16'(tab_raw[k % 6]);
                default: raw = 16'($urandom);
            endcase
            st  = ($urandom_range(15) == 0);
            rdy = ($urandom_range(7) == 0);
            drive(w, st, rv, raw, rdy);
            if (rv) begin
                if (k % d == 0) begin
                    ev = (pat == 1) ? 981 : (pat == 3) ? tab_exp[k % 6] : scale_ref(int'(raw));
                    push_exp(w, cyc + 1, ev);
                    fwd++;
                end
                k++;
            end
            @(negedge clk);
            chk("mov_stream", get_mov(w), 1);
            if (guard == 0) chk("timeout_clr_on_start", get_timeout(w), 0);
            @(posedge clk); #1;
            guard++;
        end
        chk("stream_bound", guard < 4000, 1);

        extra  = $urandom_range(1, 3);
        done_t = -1;
        t      = 0;
        while (done_t < 0 && t < 400) begin
            rdy = (rel_mode == 0 && t == dly) || (rel_mode == 2 && t == TO - 1);
            drive(w, 1'b0, (t < extra), 16'($urandom), rdy);
            @(negedge clk);
            if (get_done(w)) begin
                done_t = t;
            end else begin
                chk("mov_wait", get_mov(w), 1);
                @(posedge clk); #1;
                t++;
            end
        end
        exp_done = (rel_mode == 0) ? dly + 1 : TO;
        exp_to   = (rel_mode == 1);
        chk("release_latency", done_t, exp_done);
        chk("mov_release1", get_mov(w), 0);
        chk("busy_release1", get_busy(w), 1);
        chk("timeout_flag", get_timeout(w), int'(exp_to));
        drive(w, 1'b1, 1'b0, 16'sd0, 1'b0);
        @(posedge clk); #1;
        drive(w, 1'b0, 1'b0, 16'sd0, 1'b0);
        @(negedge clk);
        chk("done_single", get_done(w), 0);
        chk("mov_release2", get_mov(w), 0);
        chk("busy_release2", get_busy(w), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("busy_idle", get_busy(w), 0);
        chk("mov_idle", get_mov(w), 0);
        chk("timeout_sticky", get_timeout(w), int'(exp_to));
        @(posedge clk); #1;
        @(negedge clk);
        chk("no_restart_from_release", get_mov(w), 0);
        chk("scoreboard_drained", qsize(w), 0);
        @(posedge clk); #1;
    endtask

    task automatic reset_abort();
        int base;
        logic signed [15:0] raw;
        drive(0, 1'b1, 1'b0, 16'sd0, 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i < 12; i++) begin
            raw = 16'($urandom);
            drive(0, 1'b0, 1'b1, raw, 1'b0);
            push_exp(0, cyc + 1, scale_ref(int'(raw)));
            @(posedge clk); #1;
        end
        drive(0, 1'b0, 1'b0, 16'sd0, 1'b0);
        @(negedge clk); #1;
        chk("twelve_strobes_seen", qsize(0), 0);
        reset = 1'b1;
        #1;
        check_zero("reset_mid_stream");
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        base = strobes_a;
        for (int i = 0; i < 10; i++) begin
            drive(0, 1'b0, 1'b1, 16'($urandom), 1'b0);
            @(posedge clk); #1;
        end
        drive(0, 1'b0, 1'b0, 16'sd0, 1'b0);
        @(negedge clk); #1;
        chk("no_strobe_without_start", strobes_a - base, 0);
        chk("mov_after_abort", mov_a, 0);
        @(posedge clk); #1;
        gesture(0, 0, 0, 3);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 16'sd0, 1'b0);
        drive(1, 1'b0, 1'b0, 16'sd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_zero("in_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_zero("after_reset");
        @(posedge clk); #1;

        gesture(0, 1, 0, 5);
        gesture(0, 3, 1, 0);
        gesture(0, 0, 0, $urandom_range(0, 20));
        gesture(1, 2, 2, 0);
        gesture(1, 0, 1, 0);
        reset_abort();
        for (int i = 0; i < 4; i++) begin
            gesture(i % 2, 0, $urandom_range(0, 2), $urandom_range(0, 30));
        end

        chk("final_queue_a", qa.size(), 0);
        chk("final_queue_b", qb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
